// File: rtl/led_shift_tx.sv
// rtl/led_shift_tx.sv - MSB-first serial driver for a 74HC595 LED chain with latch pulse.
// Optional LED_SHIFT_SKIP_SAME_EN: words equal to the last latched frame are accepted without a frame.
module led_shift_tx #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_ser,
    output logic              o_srclk,
    output logic              o_rclk,
    output logic              o_busy
);

    localparam int PW = $clog2(CLK_DIV) + 1;
    localparam int IW = $clog2(DATA_W) + 1;
    localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_MSB = IW'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LATCH,
        ST_GAP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [PW-1:0]     phase;
    logic [PW-1:0]     phase_next;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_next;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_next;
    logic              ser_next;
    logic              phase_done;
    logic              start;
`ifdef LED_SHIFT_SKIP_SAME_EN
    logic [DATA_W-1:0] last_word;
    logic [DATA_W-1:0] last_next;
`endif

    always_comb begin
        state_next = state;
        phase_next = phase + PW'(1);
        idx_next   = idx;
        shreg_next = shreg;
        ser_next   = o_ser;
        start      = 1'b0;
        phase_done = (phase == PH_LAST);
`ifdef LED_SHIFT_SKIP_SAME_EN
        last_next  = last_word;
`endif
        case (state)
            ST_IDLE: begin
                phase_next = '0;
                if (i_valid) begin
`ifdef LED_SHIFT_SKIP_SAME_EN
                    start = (i_data != last_word);
`else
                    start = 1'b1;
`endif
                end
                if (start) begin
                    state_next = ST_SHIFT_LO;
                    shreg_next = i_data;
                    idx_next   = IDX_MSB;
                    ser_next   = i_data[DATA_W-1];
                end
            end
            ST_SHIFT_LO: begin
                if (phase_done) begin
                    state_next = ST_SHIFT_HI;
                    phase_next = '0;
                end
            end
            ST_SHIFT_HI: begin
                if (phase_done) begin
                    phase_next = '0;
                    // Rotate rather than shift so the word is intact again after the last bit.
                    shreg_next = DATA_W'({shreg, shreg[DATA_W-1]});
                    if (idx == '0) begin
                        state_next = ST_LATCH;
`ifdef LED_SHIFT_SKIP_SAME_EN
                        last_next  = shreg_next;
`endif
                    end else begin
                        idx_next   = idx - IW'(1);
                        state_next = ST_SHIFT_LO;
                        ser_next   = shreg_next[DATA_W-1];
                    end
                end
            end
            ST_LATCH: begin
                if (phase_done) begin
                    state_next = ST_GAP;
                    phase_next = '0;
                end
            end
            ST_GAP: begin
                if (phase_done) begin
                    state_next = ST_IDLE;
                    phase_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                phase_next = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with the state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            phase   <= '0;
            idx     <= '0;
            shreg   <= '0;
            o_ser   <= 1'b0;
            o_srclk <= 1'b0;
            o_rclk  <= 1'b0;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
`ifdef LED_SHIFT_SKIP_SAME_EN
            last_word <= '0;
`endif
        end else begin
            state   <= state_next;
            phase   <= phase_next;
            idx     <= idx_next;
            shreg   <= shreg_next;
            o_ser   <= ser_next;
            o_srclk <= (state_next == ST_SHIFT_HI);
            o_rclk  <= (state_next == ST_LATCH);
            o_ready <= (state_next == ST_IDLE);
            o_busy  <= (state_next != ST_IDLE);
`ifdef LED_SHIFT_SKIP_SAME_EN
            last_word <= last_next;
`endif
        end
    end

endmodule

// File: tb/tb_led_shift_tx.sv
// tb/tb_led_shift_tx.sv - bench for led_shift_tx against a cycle-count model of the frame timing.
module tb_led_shift_tx;

    localparam int DW    = 16;
    localparam int CD    = 4;
    localparam int SHIFT = 2 * DW * CD;
    localparam int BUSY  = (2 * DW + 2) * CD;
`ifdef LED_SHIFT_SKIP_SAME_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data;
    logic          valid;
    logic          ready, ser, srclk, rclk, busy;
    logic          s_rst;
    logic [3:0]    s_data;
    logic          s_valid;
    logic          s_ready, s_ser, s_srclk, s_rclk, s_busy;

    always #5 clk = ~clk;

    led_shift_tx #(.DATA_W(DW), .CLK_DIV(CD)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid),
        .o_ready(ready), .o_ser(ser), .o_srclk(srclk), .o_rclk(rclk), .o_busy(busy)
    );

    led_shift_tx #(.DATA_W(4), .CLK_DIV(1)) dut_s (
        .i_clk(clk), .i_rst(s_rst), .i_data(s_data), .i_valid(s_valid),
        .o_ready(s_ready), .o_ser(s_ser), .o_srclk(s_srclk), .o_rclk(s_rclk), .o_busy(s_busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model: position in the frame is just the number of cycles since accept.
    bit            m_busy = 1'b0;
    int            m_n    = 0;
    logic [DW-1:0] m_word = '0;
    logic [DW-1:0] m_last = '0;
    logic          e_ser = 1'b0, e_srclk = 1'b0, e_rclk = 1'b0, e_ready = 1'b1;
    bit            chk_en = 1'b0;

    always @(posedge clk) begin
        int k;
        if (rst) begin
            m_busy = 1'b0;
            m_n    = 0;
            e_ser  = 1'b0;
            m_last = '0;
        end else if (m_busy) begin
            m_n++;
            if (m_n == 1 + SHIFT) m_last = m_word;
            if (m_n > BUSY) m_busy = 1'b0;
        end else if (valid) begin
            if (!(SKIP && data == m_last)) begin
                m_busy = 1'b1;
                m_n    = 1;
                m_word = data;
            end
        end
        e_ready = !m_busy;
        e_srclk = 1'b0;
        e_rclk  = 1'b0;
        if (m_busy) begin
            if (m_n - 1 < SHIFT) begin
                k       = (m_n - 1) / (2 * CD);
                e_srclk = ((m_n - 1) % (2 * CD)) >= CD;
                e_ser   = m_word[DW-1-k];
            end else begin
                e_rclk = (m_n - 1 - SHIFT) < CD;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_ready", ready, e_ready);
            chk("cyc_busy", busy, !e_ready);
            chk("cyc_srclk", srclk, e_srclk);
            chk("cyc_rclk", rclk, e_rclk);
            chk("cyc_ser", ser, e_ser);
        end
    end

    task automatic send_word(input logic [DW-1:0] w, input bit keep);
        int k;
        data  = w;
        valid = 1'b1;
        k     = 0;
        while (!ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (!ready) chk("send_timeout", ready, 1);
        @(negedge clk);
        if (!keep) valid = 1'b0;
    endtask

    task automatic measure(output logic [DW-1:0] bits, output int nb, output int rc, output int ra);
        logic prev;
        bits = '0; nb = 0; rc = 0; ra = -1; prev = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            if (srclk && !prev) begin
                bits = {bits[DW-2:0], ser};
                nb++;
            end
            prev = srclk;
            if (rclk) rc++;
            if (ready) begin
                ra = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ser"}, ser, 0);
        chk({tag, "_srclk"}, srclk, 0);
        chk({tag, "_rclk"}, rclk, 0);
        chk({tag, "_ready"}, ready, 1);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] bits, prev_w, w;
        logic [3:0]    sb;
        int            nb, rc, ra, bc, cnt, rst_at;
        logic          prev;

        rst = 1'b1; valid = 1'b0; data = '0;
        s_rst = 1'b1; s_valid = 1'b0; s_data = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        chk_en = 1'b1;
        rst    = 1'b0;

        send_word(16'hA5C3, 1'b0);
        measure(bits, nb, rc, ra);
        chk("a5c3_bits", bits, 16'hA5C3);
        chk("a5c3_nbits", nb, 16);
        chk("a5c3_rclk_width", rc, 4);
        chk("a5c3_ready_cycle", ra, 137);

        send_word(16'h1234, 1'b1);
        bits = '0; prev = 1'b0;
        for (int n = 1; n < 137; n++) begin
            if (srclk && !prev) bits = {bits[DW-2:0], ser};
            prev = srclk;
            data = (n < 130) ? 16'($urandom) : 16'hFFFF;
            @(negedge clk);
        end
        chk("b2b_first_bits", bits, 16'h1234);
        chk("b2b_ready_window", ready, 1);
        @(negedge clk);
        valid = 1'b0;
        chk("b2b_second_accept", ready, 0);
        measure(bits, nb, rc, ra);
        chk("b2b_second_bits", bits, 16'hFFFF);
        chk("b2b_second_ready", ra, 137);

        s_rst = 1'b0; s_data = 4'b1001; s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; s_data = 4'b0110;
        sb = '0; rc = 0; bc = 0; ra = -1; prev = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            if (n <= 8) chk($sformatf("small_srclk_%0d", n), s_srclk, (n % 2 == 0) ? 1 : 0);
            if (s_srclk && !prev) sb = {sb[2:0], s_ser};
            prev = s_srclk;
            if (s_rclk) rc++;
            if (s_busy) bc++;
            if (s_ready) begin
                ra = n;
                break;
            end
            @(negedge clk);
        end
        chk("small_bits", sb, 4'b1001);
        chk("small_rclk", rc, 1);
        chk("small_busy_cycles", bc, 10);
        chk("small_ready_cycle", ra, 11);

        send_word(16'h5A3C, 1'b0);
        repeat (57) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        rst = 1'b0;
        rc = 0;
        repeat (150) begin
            @(negedge clk);
            if (rclk) rc++;
        end
        chk("abort_no_rclk", rc, 0);
        send_word(16'hC0DE, 1'b0);
        measure(bits, nb, rc, ra);
        chk("after_abort_bits", bits, 16'hC0DE);
        chk("after_abort_ready", ra, 137);

`ifdef LED_SHIFT_SKIP_SAME_EN
        send_word(16'h00FF, 1'b0);
        measure(bits, nb, rc, ra);
        chk("skip_first_bits", bits, 16'h00FF);
        send_word(16'h00FF, 1'b0);
        cnt = 0;
        repeat (20) begin
            if (srclk || rclk || !ready) cnt++;
            @(negedge clk);
        end
        chk("skip_same_activity", cnt, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_word(16'h0000, 1'b0);
        cnt = 0;
        repeat (20) begin
            if (srclk || rclk || !ready) cnt++;
            @(negedge clk);
        end
        chk("skip_zero_after_reset", cnt, 0);
`endif

        prev_w = 16'hC0DE;
        for (int r = 0; r < 14; r++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            w = ($urandom_range(0, 3) == 0) ? prev_w : 16'($urandom);
            send_word(w, 1'b0);
            prev_w = w;
            rst_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 130)) : 0;
            nb = 1;
            while (!ready && nb < 400) begin
                data  = 16'($urandom);
                valid = 1'($urandom_range(0, 1));
                rst   = (nb == rst_at);
                @(negedge clk);
                nb++;
            end
            rst   = 1'b0;
            valid = 1'b0;
            chk("rand_frame_done", ready, 1);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
